regfile_wport_arb: RTL and testbench

- Arbiter and scheduler for the register file's single write port.
- Two writers share the port:
  - Pipeline writeback stage: fixed priority, no backpressure.
  - Multi-cycle unit (divider / HI-LO / late load): valid/ready handshake, buffered in a small FIFO until the port is free.
- Also provides pending-write hazard flags for decode, and a starvation stall request to the pipeline controller.

---
 rtl/regfile_wport_arb.sv | 153 +++++++++++++++
 tb/tb_regfile_wport_arb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb
//   Arbitrates the register file's single write port between the pipeline
//   writeback stage (fixed priority, never stalled by this block) and a
//   multi-cycle unit whose writes are buffered in a small FIFO until the
//   port is free. Also reports buffered pending writes to decode and
//   requests a pipeline stall when the FIFO head starves.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wdata  writeback-stage write request
//   mcu_valid/mcu_ready            multi-cycle unit handshake
//   mcu_waddr/mcu_wdata            multi-cycle unit write payload
//   rf_we/rf_waddr/rf_wdata        register file write port
//   chk_addr_1/chk_addr_2          decode source registers to check
//   pend_hit_1/pend_hit_2          source has a buffered pending write
//   stall_req                      ask pipeline to hold off pipe_we
//   fifo_count                     occupied FIFO entries
//
// Handshake: an MCU write transfers on a posedge where mcu_valid and
// mcu_ready are both high. mcu_ready depends only on the registered
// occupancy, so it never depends on mcu_valid or on a same-cycle pop.
module regfile_wport_arb #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [AW-1:0]            pipe_waddr,
  input  logic [DW-1:0]            pipe_wdata,
  input  logic                     mcu_valid,
  output logic                     mcu_ready,
  input  logic [AW-1:0]            mcu_waddr,
  input  logic [DW-1:0]            mcu_wdata,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            chk_addr_1,
  input  logic [AW-1:0]            chk_addr_2,
  output logic                     pend_hit_1,
  output logic                     pend_hit_2,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_next;

  logic pipe_req;
  logic fifo_empty;
  logic push;
  logic pop;
  logic hit_1;
  logic hit_2;
  logic [PW-1:0] offs;

  assign fifo_count = count;

  always_comb begin
    pipe_req   = pipe_we && (pipe_waddr != '0);
    fifo_empty = (count == '0);
    mcu_ready  = !rst && (count < CW'(DEPTH));
    // Register-0 MCU writes complete the handshake but are never stored.
    push       = mcu_valid && mcu_ready && (mcu_waddr != '0);
    pop        = !rst && !pipe_req && !fifo_empty;

    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (pipe_req) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_waddr = addr_mem[rd_ptr];
        rf_wdata = data_mem[rd_ptr];
      end
    end
  end

  // Wait counter: counts cycles the head is blocked, saturating.
  always_comb begin
    if (fifo_empty || pop) begin
      wait_next = '0;
    end else if (wait_cnt < WW'(MAX_WAIT)) begin
      wait_next = wait_cnt + WW'(1);
    end else begin
      wait_next = wait_cnt;
    end
  end

  // Hazard check: an entry is valid when its distance from the read
  // pointer is below the occupancy. The head being popped still counts.
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    offs  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if ({1'b0, offs} < count) begin
        if (addr_mem[i] == chk_addr_1) hit_1 = 1'b1;
        if (addr_mem[i] == chk_addr_2) hit_2 = 1'b1;
      end
    end
    pend_hit_1 = !rst && (chk_addr_1 != '0) && hit_1;
    pend_hit_2 = !rst && (chk_addr_2 != '0) && hit_2;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= mcu_waddr;
      data_mem[wr_ptr] <= mcu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wait_cnt <= wait_next;
      if (pop) begin
        stall_req <= 1'b0;
      end else if (wait_next == WW'(MAX_WAIT)) begin
        stall_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: directed scenarios plus a random mix, with
// a scoreboard queue holding the expected order of register file writes.
module tb_regfile_wport_arb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          mcu_valid;
  logic          mcu_ready;
  logic [AW-1:0] mcu_waddr;
  logic [DW-1:0] mcu_wdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] chk_addr_1;
  logic [AW-1:0] chk_addr_2;
  logic          pend_hit_1;
  logic          pend_hit_2;
  logic          stall_req;
  logic [CW-1:0] fifo_count;

  int checks;
  int failures;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] model_q[$];

  regfile_wport_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready),
    .mcu_waddr(mcu_waddr), .mcu_wdata(mcu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .pend_hit_1(pend_hit_1), .pend_hit_2(pend_hit_2),
    .stall_req(stall_req), .fifo_count(fifo_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port monitor: every observed write must match the scoreboard head.
  always @(negedge clk) begin
    logic [AW+DW-1:0] w;
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL port_write unexpected: got addr=%0d data=%h, required no write",
                 rf_waddr, rf_wdata);
      end else begin
        w = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== w) begin
          failures++;
          $display("FAIL port_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, w[AW+DW-1:DW], w[DW-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pipe_we    = 1'b0;
    pipe_waddr = '0;
    pipe_wdata = '0;
    mcu_valid  = 1'b0;
    mcu_waddr  = '0;
    mcu_wdata  = '0;
    chk_addr_1 = '0;
    chk_addr_2 = '0;
  endtask

  task automatic drive_pipe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pipe_we    = 1'b1;
    pipe_waddr = a;
    pipe_wdata = d;
    if (a != '0) exp_q.push_back({a, d});
  endtask

  task automatic drive_mcu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mcu_valid = 1'b1;
    mcu_waddr = a;
    mcu_wdata = d;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: %0d expected writes never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h55;
    mcu_valid = 1'b1; mcu_waddr = 5'd6;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || mcu_ready !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      failures++;
      $display("FAIL reset_comb: got we=%b ready=%b addr=%0d data=%h, required 0 0 0 0",
               rf_we, mcu_ready, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (fifo_count !== '0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got count=%0d stall=%b, required 0 0", fifo_count, stall_req);
    end
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if (mcu_ready !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b we=%b, required 1 0", mcu_ready, rf_we);
    end
    tick();
  endtask

  task automatic test_pipe_only();
    drive_pipe(5'd5, 32'h1234);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      failures++;
      $display("FAIL pipe_only: got we=%b addr=%0d data=%h, required 1 5 1234",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_pipe(AW'($urandom_range(1, 31)), $urandom);
      tick();
    end
    set_idle();
    checks++;
    if (fifo_count !== '0) begin
      failures++;
      $display("FAIL pipe_only_count: got %0d, required 0", fifo_count);
    end
    tick();
    check_drained("pipe_only");
  endtask

  task automatic test_mcu_idle();
    drive_mcu(5'd7, 32'hAAAA);
    chk_addr_1 = 5'd7;
    exp_q.push_back({5'd7, 32'hAAAA});
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || pend_hit_1 !== 1'b0) begin
      failures++;
      $display("FAIL mcu_no_bypass: got we=%b addr=%0d data=%h hit=%b, required 0 0 0 0",
               rf_we, rf_waddr, rf_wdata, pend_hit_1);
    end
    tick();
    mcu_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL mcu_push_count: got %0d, required 1", fifo_count);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || pend_hit_1 !== 1'b1) begin
      failures++;
      $display("FAIL mcu_drain: got we=%b addr=%0d hit=%b, required 1 7 1",
               rf_we, rf_waddr, pend_hit_1);
    end
    tick();
    checks++;
    if (fifo_count !== '0 || pend_hit_1 !== 1'b0) begin
      failures++;
      $display("FAIL mcu_after_pop: got count=%0d hit=%b, required 0 0", fifo_count, pend_hit_1);
    end
    set_idle();
    tick();
    check_drained("mcu_idle");
  endtask

  task automatic test_fill_full();
    logic [DW-1:0] d [4];
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      drive_pipe(AW'($urandom_range(1, 31)), $urandom);
      drive_mcu(AW'(10 + i), d[i]);
      @(negedge clk);
      checks++;
      if (mcu_ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_ready_%0d: got %b, required 1", i, mcu_ready);
      end
      tick();
    end
    checks++;
    if (fifo_count !== 3'd4 || mcu_ready !== 1'b0 || stall_req !== 1'b1) begin
      failures++;
      $display("FAIL full_state: got count=%0d ready=%b stall=%b, required 4 0 1",
               fifo_count, mcu_ready, stall_req);
    end
    pipe_we = 1'b0;
    drive_mcu(5'd20, 32'hDEAD);
    chk_addr_1 = 5'd20;
    chk_addr_2 = 5'd12;
    for (int i = 0; i < 4; i++) exp_q.push_back({AW'(10 + i), d[i]});
    @(negedge clk);
    checks++;
    if (mcu_ready !== 1'b0 || pend_hit_1 !== 1'b0 || pend_hit_2 !== 1'b1) begin
      failures++;
      $display("FAIL full_reject: got ready=%b hit1=%b hit2=%b, required 0 0 1",
               mcu_ready, pend_hit_1, pend_hit_2);
    end
    tick();
    mcu_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd3 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL full_first_pop: got count=%0d stall=%b, required 3 0", fifo_count, stall_req);
    end
    repeat (3) tick();
    checks++;
    if (fifo_count !== '0 || pend_hit_1 !== 1'b0 || pend_hit_2 !== 1'b0) begin
      failures++;
      $display("FAIL full_drain: got count=%0d hit1=%b hit2=%b, required 0 0 0",
               fifo_count, pend_hit_1, pend_hit_2);
    end
    set_idle();
    tick();
    check_drained("fill_full");
  endtask

  task automatic test_starvation();
    drive_mcu(5'd9, 32'h9999);
    drive_pipe(AW'($urandom_range(1, 31)), $urandom);
    tick();
    mcu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_pipe(AW'($urandom_range(1, 31)), $urandom);
      tick();
      checks++;
      if (stall_req !== (i == 2)) begin
        failures++;
        $display("FAIL starve_stall_%0d: got %b, required %b", i, stall_req, (i == 2));
      end
    end
    pipe_we = 1'b0;
    exp_q.push_back({5'd9, 32'h9999});
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b1 || rf_waddr !== 5'd9) begin
      failures++;
      $display("FAIL starve_release: got stall=%b addr=%0d, required 1 9", stall_req, rf_waddr);
    end
    tick();
    checks++;
    if (stall_req !== 1'b0 || fifo_count !== '0) begin
      failures++;
      $display("FAIL starve_clear: got stall=%b count=%0d, required 0 0", stall_req, fifo_count);
    end
    set_idle();
    tick();
    check_drained("starvation");
  endtask

  task automatic test_reg0();
    drive_mcu(5'd3, 32'h3333);
    drive_pipe(5'd0, 32'hBEEF);
    tick();
    mcu_valid = 1'b0;
    drive_pipe(5'd0, 32'hBEEF);
    exp_q.push_back({5'd3, 32'h3333});
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333) begin
      failures++;
      $display("FAIL reg0_pipe_drop: got we=%b addr=%0d data=%h, required 1 3 3333",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    set_idle();
    drive_mcu(5'd0, 32'h0BAD);
    @(negedge clk);
    checks++;
    if (mcu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reg0_mcu_ready: got %b, required 1", mcu_ready);
    end
    tick();
    mcu_valid = 1'b0;
    checks++;
    if (fifo_count !== '0) begin
      failures++;
      $display("FAIL reg0_mcu_count: got %0d, required 0", fifo_count);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reg0_no_write: got we=%b, required 0", rf_we);
    end
    tick();
    check_drained("reg0");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive_pipe(AW'($urandom_range(1, 31)), $urandom);
      if (i < 3) drive_mcu(AW'(20 + i), $urandom);
      else mcu_valid = 1'b0;
      tick();
    end
    checks++;
    if (fifo_count !== 3'd3 || stall_req !== 1'b1) begin
      failures++;
      $display("FAIL rmid_setup: got count=%0d stall=%b, required 3 1", fifo_count, stall_req);
    end
    set_idle();
    chk_addr_1 = 5'd20;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || mcu_ready !== 1'b0 || pend_hit_1 !== 1'b0) begin
      failures++;
      $display("FAIL rmid_forced: got we=%b ready=%b hit=%b, required 0 0 0",
               rf_we, mcu_ready, pend_hit_1);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (fifo_count !== '0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL rmid_cleared: got count=%0d stall=%b, required 0 0", fifo_count, stall_req);
    end
    repeat (4) tick();
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    logic exp_ready;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    model_q.delete();
    for (int c = 0; c < 200; c++) begin
      pa = AW'($urandom_range(0, 31));
      pd = $urandom;
      ma = AW'($urandom_range(0, 7));
      md = $urandom;
      pipe_we    = (stall_req === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
      pipe_waddr = pa;
      pipe_wdata = pd;
      mcu_valid  = 1'($urandom_range(0, 1));
      mcu_waddr  = ma;
      mcu_wdata  = md;
      exp_ready  = (model_q.size() < DEPTH);
      if (pipe_we && pa != '0) exp_q.push_back({pa, pd});
      else if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      if (mcu_valid && exp_ready && ma != '0) model_q.push_back({ma, md});
      @(negedge clk);
      checks++;
      if (mcu_ready !== exp_ready) begin
        failures++;
        $display("FAIL b2b_ready cycle %0d: got %b, required %b", c, mcu_ready, exp_ready);
      end
      tick();
      checks++;
      if (fifo_count !== CW'(model_q.size())) begin
        failures++;
        $display("FAIL b2b_count cycle %0d: got %0d, required %0d", c, fifo_count, model_q.size());
      end
    end
    set_idle();
    while (model_q.size() > 0) begin
      exp_q.push_back(model_q.pop_front());
      tick();
    end
    tick();
    check_drained("back_to_back");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_pipe_only();
    test_mcu_idle();
    test_fill_full();
    test_starvation();
    test_reg0();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
